// File: rtl/prim_clock_switch_pkg.sv
// rtl/prim_clock_switch_pkg.sv - shared types and constants for the clock switch controller
//
// Contents:
//   sw_state_e : controller state (IDLE, GATE, SETTLE, DONE), 2-bit
//   SwCntW     : width of the optional switch counter
//   max_int    : constant-foldable max used for timer sizing
package prim_clock_switch_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GATE   = 2'd1,
    SETTLE = 2'd2,
    DONE   = 2'd3
  } sw_state_e;

  localparam int SwCntW = 8;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prim_clock_switch_timer.sv
// rtl/prim_clock_switch_timer.sv - loadable down-counter with terminal flag
//
// Ports:
//   clk_i      : clock
//   rst_i      : synchronous active-high reset, clears count to 0
//   load_i     : load load_val_i this edge (has priority over counting)
//   load_val_i : value to load; done_o rises load_val_i cycles later
//   done_o     : count has reached zero
module prim_clock_switch_timer #(
  parameter int W = 3
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q, cnt_d;

  // Stops at zero rather than wrapping; callers only look at the terminal flag.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/prim_clock_switch_ctrl.sv
// rtl/prim_clock_switch_ctrl.sv - glitch-free sequencing of a 2:1 clock mux and its ICG
//
// Optional feature macro: PRIM_CLK_SWITCH_CNT_EN (adds switch_cnt_o).
//
// Ports:
//   clk_i        : always-on reference clock
//   rst_i        : synchronous active-high reset
//   req_i        : switch request level, held until ack_o
//   req_sel_i    : requested source, captured when the request is accepted
//   sel_o        : mux select (registered)
//   gate_en_o    : ICG enable after the mux (registered)
//   ack_o        : switch complete (registered)
//   busy_o       : controller is not idle
//   switch_cnt_o : saturating count of real source changes (macro only)
module prim_clock_switch_ctrl
  import prim_clock_switch_pkg::*;
#(
  parameter int   GateCycles   = 4,
  parameter int   SettleCycles = 2,
  parameter logic DefaultSel   = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              req_i,
  input  logic              req_sel_i,
  output logic              sel_o,
  output logic              gate_en_o,
  output logic              ack_o,
  output logic              busy_o
`ifdef PRIM_CLK_SWITCH_CNT_EN
  ,
  output logic [SwCntW-1:0] switch_cnt_o
`endif
);

  localparam int CntW = $clog2(max_int(GateCycles, SettleCycles) + 1);

  if (GateCycles < 1 || SettleCycles < 1) begin : g_bad_params
    $error("prim_clock_switch_ctrl: GateCycles and SettleCycles must both be >= 1");
  end

  sw_state_e       state_q, state_d;
  logic            sel_q, sel_d;
  logic            gate_en_q, gate_en_d;
  logic            ack_q, ack_d;
  logic            tgt_q, tgt_d;
  logic            tmr_load;
  logic [CntW-1:0] tmr_val;
  logic            tmr_done;

  prim_clock_switch_timer #(
    .W (CntW)
  ) u_timer (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Every output change is staged into its own flop on the transition edge,
  // so the mux and ICG never see a decoded or input-dependent glitch.
  // The timer is loaded with N-1 on entry so the state lasts exactly N cycles.
  always_comb begin
    state_d   = state_q;
    sel_d     = sel_q;
    gate_en_d = gate_en_q;
    ack_d     = ack_q;
    tgt_d     = tgt_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    case (state_q)
      IDLE: begin
        if (req_i) begin
          tgt_d    = req_sel_i;
          tmr_load = 1'b1;
          if (req_sel_i != sel_q) begin
            state_d   = GATE;
            gate_en_d = 1'b0;
            tmr_val   = CntW'(GateCycles - 1);
          end else begin
            // Already on the requested source: acknowledge without touching the gate.
            state_d = DONE;
            ack_d   = 1'b1;
          end
        end
      end
      GATE: begin
        if (tmr_done) begin
          state_d  = SETTLE;
          sel_d    = tgt_q;
          tmr_load = 1'b1;
          tmr_val  = CntW'(SettleCycles - 1);
        end
      end
      SETTLE: begin
        if (tmr_done) begin
          state_d   = DONE;
          gate_en_d = 1'b1;
          ack_d     = 1'b1;
          tmr_load  = 1'b1;
        end
      end
      DONE: begin
        if (!req_i) begin
          state_d  = IDLE;
          ack_d    = 1'b0;
          tmr_load = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      sel_q     <= DefaultSel;
      gate_en_q <= 1'b1;
      ack_q     <= 1'b0;
      tgt_q     <= DefaultSel;
    end else begin
      state_q   <= state_d;
      sel_q     <= sel_d;
      gate_en_q <= gate_en_d;
      ack_q     <= ack_d;
      tgt_q     <= tgt_d;
    end
  end

  assign sel_o     = sel_q;
  assign gate_en_o = gate_en_q;
  assign ack_o     = ack_q;
  assign busy_o    = (state_q != IDLE);

`ifdef PRIM_CLK_SWITCH_CNT_EN
  logic [SwCntW-1:0] sw_cnt_q, sw_cnt_d;

  // Counts only GATE->SETTLE, i.e. real source changes; same-source requests skip GATE.
  always_comb begin
    sw_cnt_d = sw_cnt_q;
    if (state_q == GATE && tmr_done && sw_cnt_q != '1) begin
      sw_cnt_d = sw_cnt_q + SwCntW'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sw_cnt_q <= '0;
    end else begin
      sw_cnt_q <= sw_cnt_d;
    end
  end

  assign switch_cnt_o = sw_cnt_q;
`endif

endmodule

// File: tb/tb_prim_clock_switch_ctrl.sv
// tb/tb_prim_clock_switch_ctrl.sv - self-checking bench for prim_clock_switch_ctrl
//
// Ports: none (top-level bench). Honours PRIM_CLK_SWITCH_CNT_EN.
module tb_prim_clock_switch_ctrl;

  localparam int G = 4;
  localparam int S = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       req_i;
  logic       req_sel_i;
  logic       sel_o;
  logic       gate_en_o;
  logic       ack_o;
  logic       busy_o;
`ifdef PRIM_CLK_SWITCH_CNT_EN
  logic [7:0] switch_cnt_o;
`endif

  prim_clock_switch_ctrl #(
    .GateCycles   (G),
    .SettleCycles (S),
    .DefaultSel   (1'b0)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .req_i        (req_i),
    .req_sel_i    (req_sel_i),
    .sel_o        (sel_o),
    .gate_en_o    (gate_en_o),
    .ack_o        (ack_o),
    .busy_o       (busy_o)
`ifdef PRIM_CLK_SWITCH_CNT_EN
    ,
    .switch_cnt_o (switch_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: a switch accepted at edge t1 has a fixed timeline
  // relative to t1; the only open-ended part is how long ack is held.
  bit valid = 0;
  bit active = 0;
  bit real_sw;
  bit tgt;
  bit cur_sel;
  int t1;
  int ack_start;
  int cyc = 0;
  int exp_cnt = 0;

  always @(posedge clk_i) begin
    cyc++;
    if (rst_i) begin
      valid   = 1;
      active  = 0;
      cur_sel = 0;
      exp_cnt = 0;
    end else if (valid) begin
      if (active && real_sw && cyc == t1 + G && exp_cnt < 255) exp_cnt++;
      if (active) begin
        if (cyc - 1 >= ack_start && !req_i) begin
          active = 0;
          if (real_sw) cur_sel = tgt;
        end
      end else if (req_i) begin
        active    = 1;
        t1        = cyc;
        tgt       = req_sel_i;
        real_sw   = (req_sel_i != cur_sel);
        ack_start = real_sw ? cyc + G + S : cyc;
      end
    end
  end

  always @(negedge clk_i) begin
    if (valid) begin
      check("m_gate", 32'(gate_en_o), 32'(!(active && real_sw && cyc < ack_start)));
      check("m_sel",  32'(sel_o), 32'((active && real_sw && cyc >= t1 + G) ? tgt : cur_sel));
      check("m_ack",  32'(ack_o), 32'(active && cyc >= ack_start));
      check("m_busy", 32'(busy_o), 32'(active));
`ifdef PRIM_CLK_SWITCH_CNT_EN
      check("m_cnt",  32'(switch_cnt_o), 32'(exp_cnt));
`endif
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    req_i = 0;
    for (int i = 0; i < n; i++) step();
  endtask

  // Starts a request in the current cycle (T) and records outputs at T+1..T+n.
  task automatic run_seq(input bit tsel, input int drop_at, input int flip_at,
                         input int rst_at, input int n,
                         output logic [15:0] g, output logic [15:0] s,
                         output logic [15:0] a, output logic [15:0] b);
    g = '0; s = '0; a = '0; b = '0;
    req_i = 1;
    req_sel_i = tsel;
    for (int i = 1; i <= n; i++) begin
      step();
      g[i] = gate_en_o;
      s[i] = sel_o;
      a[i] = ack_o;
      b[i] = busy_o;
      if (i == drop_at) req_i = 0;
      if (i == flip_at) req_sel_i = !req_sel_i;
      rst_i = (i == rst_at);
    end
    req_i = 0;
    rst_i = 0;
  endtask

  logic [15:0] g, s, a, b;

  initial begin
    rst_i = 1; req_i = 0; req_sel_i = 0;
    step(); step();
    rst_i = 0;

    for (int i = 0; i < 10; i++) begin
      step();
      check("rst_sel", 32'(sel_o), 32'd0);
      check("rst_gate", 32'(gate_en_o), 32'd1);
      check("rst_ack", 32'(ack_o), 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
    end

    run_seq(1'b0, 1, 0, 0, 3, g, s, a, b);
    check("same_gate", 32'(g[3:1]), 32'b111);
    check("same_sel",  32'(s[3:1]), 32'b000);
    check("same_ack",  32'(a[3:1]), 32'b001);
    check("same_busy", 32'(b[3:1]), 32'b001);
    idle(2);

    run_seq(1'b1, 8, 0, 0, 9, g, s, a, b);
    check("sw_gate", 32'(g[9:1]), 32'b111000000);
    check("sw_sel",  32'(s[9:1]), 32'b111110000);
    check("sw_ack",  32'(a[9:1]), 32'b011000000);
    check("sw_busy", 32'(b[9:1]), 32'b011111111);
    idle(2);

    run_seq(1'b0, 3, 2, 0, 9, g, s, a, b);
    check("mid_gate", 32'(g[9:1]), 32'b111000000);
    check("mid_sel",  32'(s[9:1]), 32'b000001111);
    check("mid_ack",  32'(a[9:1]), 32'b001000000);
    check("mid_busy", 32'(b[9:1]), 32'b001111111);
    idle(2);

    run_seq(1'b1, 5, 0, 5, 7, g, s, a, b);
    check("rmid_gate", 32'(g[7:1]), 32'b1100000);
    check("rmid_sel",  32'(s[7:1]), 32'b0010000);
    check("rmid_ack",  32'(a[7:1]), 32'b0000000);
    check("rmid_busy", 32'(b[7:1]), 32'b0011111);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      step();
      req_i = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 3) == 0) req_sel_i = 1'($urandom_range(0, 1));
      rst_i = ($urandom_range(0, 199) == 0);
    end
    rst_i = 0;
    idle(2);

`ifdef PRIM_CLK_SWITCH_CNT_EN
    rst_i = 1;
    step();
    rst_i = 0;
    step();
    run_seq(1'b1, 1, 0, 0, 8, g, s, a, b); idle(1);
    run_seq(1'b1, 1, 0, 0, 2, g, s, a, b); idle(1);
    run_seq(1'b0, 1, 0, 0, 8, g, s, a, b); idle(1);
    run_seq(1'b0, 1, 0, 0, 2, g, s, a, b); idle(1);
    run_seq(1'b1, 1, 0, 0, 8, g, s, a, b); idle(1);
    check("cnt_three", 32'(switch_cnt_o), 32'd3);
    for (int i = 0; i < 257; i++) begin
      run_seq(1'(i % 2 == 0 ? 0 : 1), 1, 0, 0, 8, g, s, a, b);
      idle(1);
    end
    check("cnt_sat", 32'(switch_cnt_o), 32'd255);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
